mem_req_driver: RTL and testbench

// - Upstream stage of mem_ctrl. Accepts one 4-bit request per channel (sdram, flash, rom) over a valid/ready handshake.
// - Serialises each request into the multi-cycle valid-burst protocol mem_ctrl expects, so every burst lands that channel in BUSY.
// - sync_mode launches all three bursts in the same cycle, so the three channels reach BUSY together.

---
 rtl/mem_req_driver_if.sv | 36 +++
 rtl/mem_req_driver.sv | 192 +++++++++++++++++++
 tb/tb_mem_req_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_driver_if.sv
// Handshake bundle for mem_req_driver: three upstream request ports
// plus the valid/ready/data lanes toward mem_ctrl.
interface mem_req_driver_if;
  logic       s_req_valid;
  logic [3:0] s_req_data;
  logic       s_req_ready;
  logic       f_req_valid;
  logic [3:0] f_req_data;
  logic       f_req_ready;
  logic       r_req_valid;
  logic [3:0] r_req_data;
  logic       r_req_ready;
  logic       sdram_ready;
  logic       flash_ready;
  logic       rom_ready;
  logic       sdram_valid;
  logic [1:0] sdram_data_o;
  logic       flash_valid;
  logic [3:0] flash_data_o;
  logic       rom_valid;
  logic       rom_data_o;

  modport master (
    input  s_req_valid, s_req_data, f_req_valid, f_req_data, r_req_valid, r_req_data,
    output s_req_ready, f_req_ready, r_req_ready,
    input  sdram_ready, flash_ready, rom_ready,
    output sdram_valid, sdram_data_o, flash_valid, flash_data_o, rom_valid, rom_data_o
  );

  modport slave (
    output s_req_valid, s_req_data, f_req_valid, f_req_data, r_req_valid, r_req_data,
    input  s_req_ready, f_req_ready, r_req_ready,
    output sdram_ready, flash_ready, rom_ready,
    input  sdram_valid, sdram_data_o, flash_valid, flash_data_o, rom_valid, rom_data_o
  );
endinterface

// File: rtl/mem_req_driver.sv
// Upstream stage of mem_ctrl: turns one 4-bit request per channel into a
// fixed-length valid burst followed by a forced valid-low gap.
module mem_req_driver #(
  parameter int BURST_LEN  = 5,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sync_mode,
  input  logic             abort,
  mem_req_driver_if.master bus,
  output logic [2:0]       done,
  output logic [CNT_W-1:0] s_cnt,
  output logic [CNT_W-1:0] f_cnt,
  output logic [CNT_W-1:0] r_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
  localparam logic [1:0] LAST_GAP  = 2'(GAP_CYCLES - 1);
  // Channel indices follow the {s,f,r} bit order of done.
  localparam int S = 2;
  localparam int F = 1;
  localparam int R = 0;

  function automatic logic [1:0] sdram_beat(input logic [3:0] d, input logic [2:0] b);
    logic [1:0] v;
    case (b)
      3'd0:    v = d[1:0];
      3'd1:    v = d[3:2];
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] flash_beat(input logic [3:0] d, input logic [2:0] b);
    logic [3:0] v;
    if (b == 3'd0) v = d;
    else           v = 4'h0;
    return v;
  endfunction

  function automatic logic rom_beat(input logic [3:0] d, input logic [2:0] b);
    logic v;
    case (b)
      3'd0:    v = d[0];
      3'd1:    v = d[1];
      3'd2:    v = d[2];
      default: v = d[3];
    endcase
    return v;
  endfunction

  logic [2:0]       req_valid_s;
  logic [2:0]       mem_ready_s;
  logic [2:0]       launch_s;
  logic [2:0]       done_nxt_s;
  logic             all_armed_s;
  logic [3:0]       req_data_s  [3];
  logic [1:0]       state_r     [3];
  logic [1:0]       state_nxt_s [3];
  logic [3:0]       data_r      [3];
  logic [3:0]       data_nxt_s  [3];
  logic [2:0]       beat_r      [3];
  logic [2:0]       beat_nxt_s  [3];
  logic [1:0]       gap_r       [3];
  logic [1:0]       gap_nxt_s   [3];
  logic [CNT_W-1:0] cnt_r       [3];
  logic [2:0]       req_ready_r;
  logic [2:0]       done_r;
  logic             sdram_valid_r;
  logic [1:0]       sdram_data_r;
  logic             flash_valid_r;
  logic [3:0]       flash_data_r;
  logic             rom_valid_r;
  logic             rom_data_r;

  assign req_valid_s    = {bus.s_req_valid, bus.f_req_valid, bus.r_req_valid};
  assign mem_ready_s    = {bus.sdram_ready, bus.flash_ready, bus.rom_ready};
  assign req_data_s[S]  = bus.s_req_data;
  assign req_data_s[F]  = bus.f_req_data;
  assign req_data_s[R]  = bus.r_req_data;

  // Next-state logic for the three channel FSMs, including launch arbitration.
  always_comb begin
    all_armed_s = (state_r[S] == ST_ARMED) && (state_r[F] == ST_ARMED) && (state_r[R] == ST_ARMED);
    launch_s    = 3'b000;
    done_nxt_s  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      state_nxt_s[i] = state_r[i];
      data_nxt_s[i]  = data_r[i];
      beat_nxt_s[i]  = beat_r[i];
      gap_nxt_s[i]   = gap_r[i];
      if (sync_mode) launch_s[i] = all_armed_s && (mem_ready_s == 3'b111);
      else           launch_s[i] = (state_r[i] == ST_ARMED) && mem_ready_s[i];
      case (state_r[i])
        ST_IDLE: begin
          if (req_valid_s[i]) begin
            state_nxt_s[i] = ST_ARMED;
            data_nxt_s[i]  = req_data_s[i];
          end else begin
            state_nxt_s[i] = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (launch_s[i]) begin
            state_nxt_s[i] = ST_BURST;
            beat_nxt_s[i]  = 3'd0;
          end else begin
            state_nxt_s[i] = ST_ARMED;
          end
        end
        ST_BURST: begin
          if (abort) begin
            state_nxt_s[i] = ST_IDLE;
          end else if (beat_r[i] == LAST_BEAT) begin
            state_nxt_s[i] = ST_GAP;
            gap_nxt_s[i]   = 2'd0;
          end else begin
            beat_nxt_s[i]  = beat_r[i] + 3'd1;
          end
        end
        ST_GAP: begin
          if (abort || (gap_r[i] == LAST_GAP)) begin
            state_nxt_s[i] = ST_IDLE;
          end else begin
            gap_nxt_s[i]   = gap_r[i] + 2'd1;
          end
        end
        default: state_nxt_s[i] = ST_IDLE;
      endcase
      done_nxt_s[i] = (state_nxt_s[i] == ST_BURST) && (beat_nxt_s[i] == LAST_BEAT);
    end
  end

  // State, counters and all outputs registered from the next-state values.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= ST_IDLE;
        data_r[i]  <= 4'h0;
        beat_r[i]  <= 3'd0;
        gap_r[i]   <= 2'd0;
        cnt_r[i]   <= '0;
      end
      req_ready_r   <= 3'b111;
      done_r        <= 3'b000;
      sdram_valid_r <= 1'b0;
      sdram_data_r  <= 2'b00;
      flash_valid_r <= 1'b0;
      flash_data_r  <= 4'h0;
      rom_valid_r   <= 1'b0;
      rom_data_r    <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_r[i]     <= state_nxt_s[i];
        data_r[i]      <= data_nxt_s[i];
        beat_r[i]      <= beat_nxt_s[i];
        gap_r[i]       <= gap_nxt_s[i];
        req_ready_r[i] <= (state_nxt_s[i] == ST_IDLE);
        if (done_nxt_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) cnt_r[i] <= cnt_r[i] + 1'b1;
        else                                                cnt_r[i] <= cnt_r[i];
      end
      done_r        <= done_nxt_s;
      sdram_valid_r <= (state_nxt_s[S] == ST_BURST);
      sdram_data_r  <= (state_nxt_s[S] == ST_BURST) ? sdram_beat(data_nxt_s[S], beat_nxt_s[S]) : 2'b00;
      flash_valid_r <= (state_nxt_s[F] == ST_BURST);
      flash_data_r  <= (state_nxt_s[F] == ST_BURST) ? flash_beat(data_nxt_s[F], beat_nxt_s[F]) : 4'h0;
      rom_valid_r   <= (state_nxt_s[R] == ST_BURST);
      rom_data_r    <= (state_nxt_s[R] == ST_BURST) ? rom_beat(data_nxt_s[R], beat_nxt_s[R]) : 1'b0;
    end
  end

  assign bus.s_req_ready  = req_ready_r[S];
  assign bus.f_req_ready  = req_ready_r[F];
  assign bus.r_req_ready  = req_ready_r[R];
  assign bus.sdram_valid  = sdram_valid_r;
  assign bus.sdram_data_o = sdram_data_r;
  assign bus.flash_valid  = flash_valid_r;
  assign bus.flash_data_o = flash_data_r;
  assign bus.rom_valid    = rom_valid_r;
  assign bus.rom_data_o   = rom_data_r;
  assign done  = done_r;
  assign s_cnt = cnt_r[S];
  assign f_cnt = cnt_r[F];
  assign r_cnt = cnt_r[R];

endmodule

// File: tb/tb_mem_req_driver.sv
// Directed bench for mem_req_driver (BURST_LEN 5, GAP_CYCLES 1, CNT_W 2).
module tb_mem_req_driver;
  localparam int CNT_W = 2;

  logic             clock;
  logic             reset;
  logic             sync_mode;
  logic             abort;
  logic [2:0]       done;
  logic [CNT_W-1:0] s_cnt;
  logic [CNT_W-1:0] f_cnt;
  logic [CNT_W-1:0] r_cnt;
  int               n_cmp;
  int               n_fail;

  mem_req_driver_if bus_i ();

  mem_req_driver #(.BURST_LEN(5), .GAP_CYCLES(1), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .sync_mode (sync_mode),
    .abort     (abort),
    .bus       (bus_i),
    .done      (done),
    .s_cnt     (s_cnt),
    .f_cnt     (f_cnt),
    .r_cnt     (r_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    sync_mode = 1'b0;
    abort = 1'b0;
    bus_i.s_req_valid = 1'b0; bus_i.s_req_data = 4'h0;
    bus_i.f_req_valid = 1'b0; bus_i.f_req_data = 4'h0;
    bus_i.r_req_valid = 1'b0; bus_i.r_req_data = 4'h0;
    bus_i.sdram_ready = 1'b0; bus_i.flash_ready = 1'b0; bus_i.rom_ready = 1'b0;
    step(2);

    // Reset state
    check("rst_ready", {bus_i.s_req_ready, bus_i.f_req_ready, bus_i.r_req_ready}, 3'b111);
    check("rst_valid", {bus_i.sdram_valid, bus_i.flash_valid, bus_i.rom_valid}, 3'b000);
    check("rst_data", {bus_i.sdram_data_o, bus_i.flash_data_o, bus_i.rom_data_o}, 7'd0);
    check("rst_done", done, 3'b000);
    check("rst_cnt", {s_cnt, f_cnt, r_cnt}, 6'd0);
    reset = 1'b0;

    // Single sdram burst, d = 4'hB
    bus_i.sdram_ready = 1'b1;
    bus_i.s_req_valid = 1'b1; bus_i.s_req_data = 4'hB;
    step(1);
    check("s_armed_ready", bus_i.s_req_ready, 1'b0);
    check("s_armed_valid", bus_i.sdram_valid, 1'b0);
    bus_i.s_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("s_beat_valid", bus_i.sdram_valid, 1'b1);
      check("s_beat_data", bus_i.sdram_data_o, (k == 0) ? 2'b11 : (k == 1) ? 2'b10 : 2'b00);
      check("s_beat_done", done, (k == 4) ? 3'b100 : 3'b000);
    end
    step(1);
    check("s_gap_valid", bus_i.sdram_valid, 1'b0);
    check("s_gap_data", bus_i.sdram_data_o, 2'b00);
    check("s_gap_ready", bus_i.s_req_ready, 1'b0);
    check("s_cnt1", s_cnt, 2'd1);
    step(1);
    check("s_idle_ready", bus_i.s_req_ready, 1'b1);

    // Rom burst, d = 4'b1010 -> 0,1,0,1,1
    bus_i.rom_ready = 1'b1;
    bus_i.r_req_valid = 1'b1; bus_i.r_req_data = 4'b1010;
    step(1);
    bus_i.r_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("r_beat_valid", bus_i.rom_valid, 1'b1);
      check("r_beat_data", bus_i.rom_data_o, (k == 0 || k == 2) ? 1'b0 : 1'b1);
      check("r_beat_done", done, (k == 4) ? 3'b001 : 3'b000);
    end
    step(1);
    check("r_gap_valid", bus_i.rom_valid, 1'b0);
    check("r_gap_ready", bus_i.r_req_ready, 1'b0);
    check("r_cnt1", r_cnt, 2'd1);
    step(1);
    check("r_idle_ready", bus_i.r_req_ready, 1'b1);

    // Sync triple held off by flash_ready for 3 cycles
    sync_mode = 1'b1;
    bus_i.flash_ready = 1'b0;
    bus_i.s_req_valid = 1'b1; bus_i.s_req_data = 4'h6;
    bus_i.f_req_valid = 1'b1; bus_i.f_req_data = 4'h9;
    bus_i.r_req_valid = 1'b1; bus_i.r_req_data = 4'b0011;
    step(1);
    bus_i.s_req_valid = 1'b0; bus_i.f_req_valid = 1'b0; bus_i.r_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("sync_hold_valid", {bus_i.sdram_valid, bus_i.flash_valid, bus_i.rom_valid}, 3'b000);
      check("sync_hold_ready", {bus_i.s_req_ready, bus_i.f_req_ready, bus_i.r_req_ready}, 3'b000);
    end
    bus_i.flash_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("sync_valid", {bus_i.sdram_valid, bus_i.flash_valid, bus_i.rom_valid}, 3'b111);
      check("sync_s_data", bus_i.sdram_data_o, (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00);
      check("sync_f_data", bus_i.flash_data_o, (k == 0) ? 4'h9 : 4'h0);
      check("sync_r_data", bus_i.rom_data_o, (k <= 1) ? 1'b1 : 1'b0);
      check("sync_done", done, (k == 4) ? 3'b111 : 3'b000);
    end
    step(2);
    check("sync_cnts", {s_cnt, f_cnt, r_cnt}, {2'd2, 2'd1, 2'd2});
    check("sync_idle", {bus_i.s_req_ready, bus_i.f_req_ready, bus_i.r_req_ready}, 3'b111);
    sync_mode = 1'b0;

    // Abort at beat 2 of a flash burst
    bus_i.f_req_valid = 1'b1; bus_i.f_req_data = 4'h5;
    step(1);
    bus_i.f_req_valid = 1'b0;
    step(1);
    check("abort_b0_data", bus_i.flash_data_o, 4'h5);
    step(2);
    check("abort_b2_valid", bus_i.flash_valid, 1'b1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_valid", bus_i.flash_valid, 1'b0);
    check("abort_idle", bus_i.f_req_ready, 1'b1);
    check("abort_done", done, 3'b000);
    step(3);
    check("abort_no_done", done, 3'b000);
    check("abort_f_cnt", f_cnt, 2'd1);

    // Abort leaves an ARMED channel armed; waits for sync, then launches with sync off
    sync_mode = 1'b1;
    bus_i.r_req_valid = 1'b1; bus_i.r_req_data = 4'hC;
    step(1);
    bus_i.r_req_valid = 1'b0;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("armed_abort_ready", bus_i.r_req_ready, 1'b0);
    check("armed_abort_valid", bus_i.rom_valid, 1'b0);
    sync_mode = 1'b0;
    step(1);
    check("armed_launch_valid", bus_i.rom_valid, 1'b1);
    check("armed_launch_data", bus_i.rom_data_o, 1'b0);
    step(4);
    check("armed_last_data", bus_i.rom_data_o, 1'b1);
    check("armed_r_cnt", r_cnt, 2'd3);
    step(2);

    // sdram saturation: bursts 3, 4, 5
    for (int n = 0; n < 3; n++) begin
      bus_i.s_req_valid = 1'b1; bus_i.s_req_data = 4'h3;
      step(1);
      bus_i.s_req_valid = 1'b0;
      step(7);
      check("sat_s_cnt", s_cnt, 2'd3);
      check("sat_ready", bus_i.s_req_ready, 1'b1);
    end

    // Reset at beat 3, with abort also asserted
    bus_i.s_req_valid = 1'b1; bus_i.s_req_data = 4'hF;
    bus_i.f_req_valid = 1'b1; bus_i.f_req_data = 4'hA;
    step(1);
    bus_i.s_req_valid = 1'b0; bus_i.f_req_valid = 1'b0;
    step(4);
    check("rmid_valid_before", {bus_i.sdram_valid, bus_i.flash_valid}, 2'b11);
    reset = 1'b1;
    abort = 1'b1;
    step(1);
    reset = 1'b0;
    abort = 1'b0;
    check("rmid_valid", {bus_i.sdram_valid, bus_i.flash_valid, bus_i.rom_valid}, 3'b000);
    check("rmid_ready", {bus_i.s_req_ready, bus_i.f_req_ready, bus_i.r_req_ready}, 3'b111);
    check("rmid_cnt", {s_cnt, f_cnt, r_cnt}, 6'd0);
    check("rmid_done", done, 3'b000);
    step(3);
    check("rmid_stay_idle", {bus_i.sdram_valid, bus_i.flash_valid, bus_i.rom_valid}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
